// File: rtl/sd_dma_pkg.sv
// ---------------------------------------------------------------------------
// sd_dma_pkg
//
// Shared definitions for the SD receive DMA write master:
//   - Wishbone cycle type / burst type constants
//   - DMA state enumeration
//   - min_beats(): size of the next burst given the words still to write
// ---------------------------------------------------------------------------
package sd_dma_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_BURST,
        ST_DONE
    } dma_state_e;

    // Burst size is the smaller of the configured burst length and the
    // number of words still owed; the result always fits in 5 bits
    // because burst_len is at most 16.
    function automatic logic [4:0] min_beats(input logic [31:0] remain,
                                             input logic [4:0]  burst_len);
        if (remain < {27'd0, burst_len}) begin
            return remain[4:0];
        end
        return burst_len;
    endfunction

endpackage

// File: rtl/sd_rx_dma_writer.sv
// ---------------------------------------------------------------------------
// sd_rx_dma_writer
//
// Wishbone DMA write master that drains the show-ahead SD RX FIFO into
// system memory using incrementing linear bursts.
//
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   start           one-cycle launch pulse (ignored unless idle)
//   abort           level; terminates the transfer on the next edge
//   base_adr        byte address of the first word (sampled on start)
//   word_count      number of DW words to write (sampled on start)
//   fifo_rdata      FIFO head word (show-ahead)
//   fifo_empty      FIFO empty flag
//   fifo_level      FIFO occupancy, saturating at 16
//   fifo_rd         FIFO pop strobe (one per accepted beat)
//   m_wb_*          Wishbone master port
//   busy            transfer in progress
//   done            one-cycle pulse on successful completion
//   error           sticky bus-error flag, cleared by the next start
//
// CNT_W is limited to 32 bits; the burst-size helper works on a 32-bit
// view of the remaining word count.
// ---------------------------------------------------------------------------
module sd_rx_dma_writer
    import sd_dma_pkg::*;
#(
    parameter int DW        = 32,
    parameter int AW        = 32,
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              start,
    input  logic              abort,
    input  logic [AW-1:0]     base_adr,
    input  logic [CNT_W-1:0]  word_count,

    input  logic [DW-1:0]     fifo_rdata,
    input  logic              fifo_empty,
    input  logic [4:0]        fifo_level,
    output logic              fifo_rd,

    output logic [AW-1:0]     m_wb_adr_o,
    output logic [DW-1:0]     m_wb_dat_o,
    output logic [DW/8-1:0]   m_wb_sel_o,
    output logic              m_wb_we_o,
    output logic              m_wb_cyc_o,
    output logic              m_wb_stb_o,
    output logic [2:0]        m_wb_cti_o,
    output logic [1:0]        m_wb_bte_o,
    input  logic              m_wb_ack_i,
    input  logic              m_wb_err_i,

    output logic              busy,
    output logic              done,
    output logic              error
);

    dma_state_e       state_q;
    logic [AW-1:0]    adr_q;
    logic [CNT_W-1:0] remain_q;
    logic [4:0]       beats_q;
    logic             cyc_q;
    logic             stb_q;
    logic             we_q;
    logic [2:0]       cti_q;
    logic             done_q;
    logic             error_q;

    logic [AW-1:0]    adr_d;
    logic [CNT_W-1:0] remain_d;
    logic [4:0]       beats_d;
    logic [4:0]       burst_n;
    logic             beat_ok;
    logic             bus_err;

    // An error on the same cycle as an ack takes priority, so the beat is
    // not counted and the FIFO head stays in place.
    assign bus_err  = stb_q & m_wb_err_i;
    assign beat_ok  = stb_q & m_wb_ack_i & ~m_wb_err_i;

    assign adr_d    = adr_q + AW'(DW / 8);
    assign remain_d = remain_q - 1'b1;
    assign beats_d  = beats_q - 5'd1;
    assign burst_n  = min_beats(32'(remain_q), 5'(BURST_LEN));

    // Main transfer FSM. All Wishbone control outputs are registered here
    // so that dropping cyc/stb on the final ack happens on the same edge
    // that accepts that ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            adr_q    <= '0;
            remain_q <= '0;
            beats_q  <= '0;
            cyc_q    <= 1'b0;
            stb_q    <= 1'b0;
            we_q     <= 1'b0;
            cti_q    <= CTI_CLASSIC;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        adr_q    <= base_adr;
                        remain_q <= word_count;
                        error_q  <= 1'b0;
                        if (word_count == '0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_WAIT;
                        end
                    end
                end

                // Only launch once the whole burst is already in the FIFO,
                // so a burst never has to stall for data.
                ST_WAIT: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                    end else if (!fifo_empty && (fifo_level >= burst_n)) begin
                        beats_q <= burst_n;
                        cyc_q   <= 1'b1;
                        stb_q   <= 1'b1;
                        we_q    <= 1'b1;
                        cti_q   <= (burst_n == 5'd1) ? CTI_CLASSIC : CTI_INCR;
                        state_q <= ST_BURST;
                    end
                end

                // An ack coinciding with abort still completes its beat;
                // the later drop assignments override the cti update.
                ST_BURST: begin
                    if (bus_err) begin
                        error_q <= 1'b1;
                        cyc_q   <= 1'b0;
                        stb_q   <= 1'b0;
                        we_q    <= 1'b0;
                        cti_q   <= CTI_CLASSIC;
                        state_q <= ST_IDLE;
                    end else begin
                        if (beat_ok) begin
                            adr_q    <= adr_d;
                            remain_q <= remain_d;
                            beats_q  <= beats_d;
                            cti_q    <= (beats_d == 5'd1) ? CTI_EOB : CTI_INCR;
                        end
                        if (abort) begin
                            cyc_q   <= 1'b0;
                            stb_q   <= 1'b0;
                            we_q    <= 1'b0;
                            cti_q   <= CTI_CLASSIC;
                            state_q <= ST_IDLE;
                        end else if (beat_ok && (beats_q == 5'd1)) begin
                            cyc_q <= 1'b0;
                            stb_q <= 1'b0;
                            we_q  <= 1'b0;
                            cti_q <= CTI_CLASSIC;
                            if (remain_d == '0) begin
                                state_q <= ST_DONE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= ST_WAIT;
                            end
                        end
                    end
                end

                ST_DONE: begin
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign fifo_rd    = beat_ok;
    assign m_wb_adr_o = adr_q;
    assign m_wb_dat_o = stb_q ? fifo_rdata : '0;
    assign m_wb_sel_o = {(DW / 8){stb_q}};
    assign m_wb_we_o  = we_q;
    assign m_wb_cyc_o = cyc_q;
    assign m_wb_stb_o = stb_q;
    assign m_wb_cti_o = cti_q;
    assign m_wb_bte_o = BTE_LINEAR;

    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_sd_rx_dma_writer.sv
// ---------------------------------------------------------------------------
// tb_sd_rx_dma_writer
//
// Directed bench for sd_rx_dma_writer: a show-ahead FIFO model feeds the
// DMA, and a Wishbone slave model with optional wait states and error
// injection logs every accepted beat for later comparison.
// ---------------------------------------------------------------------------
module tb_sd_rx_dma_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] base_adr = '0;
    logic [15:0] word_count = '0;
    logic [31:0] fifo_rdata;
    logic        fifo_empty;
    logic [4:0]  fifo_level;
    logic        fifo_rd;
    logic [31:0] m_wb_adr_o;
    logic [31:0] m_wb_dat_o;
    logic [3:0]  m_wb_sel_o;
    logic        m_wb_we_o;
    logic        m_wb_cyc_o;
    logic        m_wb_stb_o;
    logic [2:0]  m_wb_cti_o;
    logic [1:0]  m_wb_bte_o;
    logic        m_wb_ack_i;
    logic        m_wb_err_i;
    logic        busy;
    logic        done;
    logic        error;

    int passCount  = 0;
    int checkCount = 0;

    // FIFO model
    logic [31:0] fifoMem [0:511];
    int          wrPtr = 0;
    int          rdPtr = 0;
    int          occ;
    logic        pushReq = 1'b0;
    logic [31:0] pushData = '0;

    // Slave model and monitor state
    int          waitCnt = 0;
    int          maxWait = 0;
    logic        errArm = 1'b0;
    int          errIdx = 0;
    logic [31:0] logAdr [0:255];
    logic [31:0] logDat [0:255];
    logic [2:0]  logCti [0:255];
    int          logCnt = 0;
    int          cycleNo = 0;
    int          cycCycles = 0;
    int          donePulses = 0;
    int          doneCycle = 0;
    int          lastAckCycle = 0;
    int          startCycle = 0;
    int          firstStbCycle = 0;
    logic        armStb = 1'b0;

    sd_rx_dma_writer #(
        .DW(32), .AW(32), .BURST_LEN(4), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .base_adr(base_adr), .word_count(word_count),
        .fifo_rdata(fifo_rdata), .fifo_empty(fifo_empty),
        .fifo_level(fifo_level), .fifo_rd(fifo_rd),
        .m_wb_adr_o(m_wb_adr_o), .m_wb_dat_o(m_wb_dat_o),
        .m_wb_sel_o(m_wb_sel_o), .m_wb_we_o(m_wb_we_o),
        .m_wb_cyc_o(m_wb_cyc_o), .m_wb_stb_o(m_wb_stb_o),
        .m_wb_cti_o(m_wb_cti_o), .m_wb_bte_o(m_wb_bte_o),
        .m_wb_ack_i(m_wb_ack_i), .m_wb_err_i(m_wb_err_i),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    // Show-ahead FIFO view and combinational slave responses
    always_comb begin
        occ        = wrPtr - rdPtr;
        fifo_empty = (occ == 0);
        fifo_level = (occ > 16) ? 5'd16 : 5'(occ);
        fifo_rdata = fifoMem[rdPtr[8:0]];
        m_wb_err_i = m_wb_stb_o && errArm && (logCnt == errIdx) && (waitCnt == 0);
        m_wb_ack_i = m_wb_stb_o && (waitCnt == 0) && !m_wb_err_i;
    end

    // FIFO pointer updates, wait-state counter and beat/event logging
    always @(posedge clk) begin
        cycleNo <= cycleNo + 1;
        if (fifo_rd) rdPtr <= rdPtr + 1;
        if (pushReq) begin
            fifoMem[wrPtr[8:0]] <= pushData;
            wrPtr <= wrPtr + 1;
        end
        if (m_wb_stb_o) begin
            if (waitCnt == 0) waitCnt <= (maxWait == 0) ? 0 : int'($urandom_range(maxWait, 0));
            else waitCnt <= waitCnt - 1;
        end
        if (m_wb_cyc_o) cycCycles <= cycCycles + 1;
        if (m_wb_stb_o && m_wb_ack_i) begin
            logAdr[logCnt] <= m_wb_adr_o;
            logDat[logCnt] <= m_wb_dat_o;
            logCti[logCnt] <= m_wb_cti_o;
            logCnt <= logCnt + 1;
            lastAckCycle <= cycleNo;
        end
        if (done) begin
            donePulses <= donePulses + 1;
            doneCycle <= cycleNo;
        end
        if (start) begin
            startCycle <= cycleNo;
            armStb <= 1'b1;
        end else if (m_wb_stb_o && armStb) begin
            firstStbCycle <= cycleNo;
            armStb <= 1'b0;
        end
    end

    task automatic pushWords(input logic [31:0] firstVal, input int count);
        for (int i = 0; i < count; i++) begin
            @(negedge clk);
            pushReq  = 1'b1;
            pushData = firstVal + 32'(i);
        end
        @(negedge clk);
        pushReq = 1'b0;
    endtask

    task automatic applyStimulus(input logic [31:0] base, input logic [15:0] cnt);
        int guard;
        @(negedge clk);
        base_adr   = base;
        word_count = cnt;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (busy && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        checkCount++;
        if (busy) $display("[TB] FAIL transfer_timeout: busy=%0b required 0", busy);
        else passCount++;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checkCount++;
        if ({m_wb_cyc_o, m_wb_stb_o, m_wb_we_o, busy, done, error, fifo_rd} !== 7'b0)
            $display("[TB] FAIL reset_ctrl: got %b required 0000000",
                     {m_wb_cyc_o, m_wb_stb_o, m_wb_we_o, busy, done, error, fifo_rd});
        else passCount++;
        checkCount++;
        if ({m_wb_adr_o, m_wb_cti_o, m_wb_sel_o, m_wb_bte_o} !== 41'd0)
            $display("[TB] FAIL reset_bus: adr=%h cti=%b sel=%b bte=%b required all 0",
                     m_wb_adr_o, m_wb_cti_o, m_wb_sel_o, m_wb_bte_o);
        else passCount++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_two_bursts();
        int b = logCnt;
        int cycBase = cycCycles;
        int doneBase = donePulses;
        logic [2:0] expCti;
        pushWords(32'h1, 8);
        applyStimulus(32'h0000_1000, 16'd8);
        for (int k = 0; k < 8; k++) begin
            expCti = (k % 4 == 3) ? 3'b111 : 3'b010;
            checkCount++;
            if (logAdr[b + k] !== 32'h1000 + 32'(4 * k))
                $display("[TB] FAIL burst8_adr[%0d]: got %h required %h", k, logAdr[b + k], 32'h1000 + 32'(4 * k));
            else passCount++;
            checkCount++;
            if (logDat[b + k] !== 32'(k + 1))
                $display("[TB] FAIL burst8_dat[%0d]: got %h required %h", k, logDat[b + k], 32'(k + 1));
            else passCount++;
            checkCount++;
            if (logCti[b + k] !== expCti)
                $display("[TB] FAIL burst8_cti[%0d]: got %b required %b", k, logCti[b + k], expCti);
            else passCount++;
        end
        checkCount++;
        if (firstStbCycle - startCycle !== 2)
            $display("[TB] FAIL start_to_stb: got %0d required 2", firstStbCycle - startCycle);
        else passCount++;
        checkCount++;
        if (cycCycles - cycBase !== 8)
            $display("[TB] FAIL burst8_cyc_cycles: got %0d required 8", cycCycles - cycBase);
        else passCount++;
        checkCount++;
        if (donePulses - doneBase !== 1 || doneCycle - lastAckCycle !== 1)
            $display("[TB] FAIL burst8_done: pulses=%0d delay=%0d required 1/1",
                     donePulses - doneBase, doneCycle - lastAckCycle);
        else passCount++;
        checkCount++;
        if (logCnt - b !== 8)
            $display("[TB] FAIL burst8_beats: got %0d required 8", logCnt - b);
        else passCount++;
    endtask

    task automatic test_partial_burst();
        int b = logCnt;
        logic [2:0] expCti [0:5] = '{3'b010, 3'b010, 3'b010, 3'b111, 3'b010, 3'b111};
        pushWords(32'h11, 6);
        applyStimulus(32'h0000_2000, 16'd6);
        checkCount++;
        if (logCnt - b !== 6) $display("[TB] FAIL burst6_beats: got %0d required 6", logCnt - b);
        else passCount++;
        for (int k = 0; k < 6; k++) begin
            checkCount++;
            if (logCti[b + k] !== expCti[k] || logDat[b + k] !== 32'h11 + 32'(k))
                $display("[TB] FAIL burst6_beat[%0d]: cti=%b dat=%h required %b %h",
                         k, logCti[b + k], logDat[b + k], expCti[k], 32'h11 + 32'(k));
            else passCount++;
        end
    endtask

    task automatic test_single_and_zero();
        int b = logCnt;
        int cycBase;
        int doneBase;
        pushWords(32'hAB, 1);
        applyStimulus(32'h0000_3000, 16'd1);
        checkCount++;
        if (logCnt - b !== 1 || logCti[b] !== 3'b000 || logAdr[b] !== 32'h3000 || logDat[b] !== 32'hAB)
            $display("[TB] FAIL single_beat: n=%0d cti=%b adr=%h dat=%h required 1 000 00003000 000000ab",
                     logCnt - b, logCti[b], logAdr[b], logDat[b]);
        else passCount++;
        cycBase  = cycCycles;
        doneBase = donePulses;
        applyStimulus(32'h0000_3100, 16'd0);
        checkCount++;
        if (cycCycles - cycBase !== 0 || donePulses - doneBase !== 1)
            $display("[TB] FAIL zero_count: cyc=%0d done=%0d required 0/1",
                     cycCycles - cycBase, donePulses - doneBase);
        else passCount++;
        checkCount++;
        if (doneCycle - startCycle !== 1)
            $display("[TB] FAIL zero_done_delay: got %0d required 1", doneCycle - startCycle);
        else passCount++;
    endtask

    task automatic test_bus_error();
        int b = logCnt;
        int rdBase;
        int doneBase = donePulses;
        pushWords(32'h21, 4);
        rdBase = rdPtr;
        errArm = 1'b1;
        errIdx = logCnt + 2;
        applyStimulus(32'h0000_4000, 16'd4);
        errArm = 1'b0;
        checkCount++;
        if (error !== 1'b1 || m_wb_cyc_o !== 1'b0)
            $display("[TB] FAIL err_flag: error=%b cyc=%b required 1/0", error, m_wb_cyc_o);
        else passCount++;
        checkCount++;
        if (rdPtr - rdBase !== 2 || logCnt - b !== 2 || donePulses - doneBase !== 0)
            $display("[TB] FAIL err_pops: pops=%0d beats=%0d done=%0d required 2/2/0",
                     rdPtr - rdBase, logCnt - b, donePulses - doneBase);
        else passCount++;
        b = logCnt;
        @(negedge clk);
        base_adr   = 32'h0000_4100;
        word_count = 16'd2;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkCount++;
        if (error !== 1'b0) $display("[TB] FAIL err_clear: got %b required 0", error);
        else passCount++;
        for (int g = 0; g < 50 && busy; g++) @(negedge clk);
        checkCount++;
        if (logCnt - b !== 2 || logDat[b] !== 32'h23 || logDat[b + 1] !== 32'h24)
            $display("[TB] FAIL err_resume: n=%0d dat=%h,%h required 2 00000023,00000024",
                     logCnt - b, logDat[b], logDat[b + 1]);
        else passCount++;
    endtask

    task automatic test_abort_and_wrap();
        int b;
        int cycBase;
        int doneBase;
        pushWords(32'h31, 2);
        cycBase  = cycCycles;
        doneBase = donePulses;
        @(negedge clk);
        base_adr   = 32'h0000_5000;
        word_count = 16'd4;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checkCount++;
        if (busy !== 1'b1) $display("[TB] FAIL abort_waiting: busy=%b required 1", busy);
        else passCount++;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkCount++;
        if (busy !== 1'b0 || cycCycles - cycBase !== 0 || donePulses - doneBase !== 0)
            $display("[TB] FAIL abort_wait: busy=%b cyc=%0d done=%0d required 0/0/0",
                     busy, cycCycles - cycBase, donePulses - doneBase);
        else passCount++;
        b = logCnt;
        applyStimulus(32'hFFFF_FFFC, 16'd2);
        checkCount++;
        if (logAdr[b] !== 32'hFFFF_FFFC || logAdr[b + 1] !== 32'h0000_0000)
            $display("[TB] FAIL wrap_adr: got %h,%h required fffffffc,00000000", logAdr[b], logAdr[b + 1]);
        else passCount++;
        checkCount++;
        if (logDat[b] !== 32'h31 || logDat[b + 1] !== 32'h32 || logCti[b] !== 3'b010 || logCti[b + 1] !== 3'b111)
            $display("[TB] FAIL wrap_data: dat=%h,%h cti=%b,%b required 31,32 010,111",
                     logDat[b], logDat[b + 1], logCti[b], logCti[b + 1]);
        else passCount++;
    endtask

    task automatic test_random_stream();
        int b = logCnt;
        int doneBase = donePulses;
        maxWait = 3;
        fork
            begin
                int i = 0;
                while (i < 64) begin
                    @(negedge clk);
                    if ($urandom_range(1, 0) == 1) begin
                        pushReq  = 1'b1;
                        pushData = 32'hC000_0000 + 32'(i);
                        i++;
                    end else begin
                        pushReq = 1'b0;
                    end
                end
                @(negedge clk);
                pushReq = 1'b0;
            end
            applyStimulus(32'h0000_8000, 16'd64);
        join
        maxWait = 0;
        checkCount++;
        if (logCnt - b !== 64 || donePulses - doneBase !== 1)
            $display("[TB] FAIL stream_count: beats=%0d done=%0d required 64/1", logCnt - b, donePulses - doneBase);
        else passCount++;
        for (int k = 0; k < 64; k++) begin
            checkCount++;
            if (logDat[b + k] !== 32'hC000_0000 + 32'(k) || logAdr[b + k] !== 32'h8000 + 32'(4 * k))
                $display("[TB] FAIL stream_beat[%0d]: adr=%h dat=%h required %h %h", k,
                         logAdr[b + k], logDat[b + k], 32'h8000 + 32'(4 * k), 32'hC000_0000 + 32'(k));
            else passCount++;
        end
    endtask

    initial begin
        test_reset();
        test_two_bursts();
        test_partial_burst();
        test_single_and_zero();
        test_bus_error();
        test_abort_and_wrap();
        test_random_stream();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/sd_rx_dma_writer.md
# sd_rx_dma_writer

Parametrised Wishbone DMA write master that drains the SD receive FIFO into system memory using incrementing bursts. It sits between the SD data-path RX FIFO (read side, `clk` domain) and the Wishbone interconnect. It replaces the single-beat RX filler with:
- configurable data/address width and burst length;
- an exact word count per transfer;
- done/error reporting and abort.

## Interface
Parameters:
- DW, 32, data width in bits; a multiple of 8.
- AW, 32, Wishbone address width.
- BURST_LEN, 4, maximum beats per Wishbone burst; range 1..16.
- CNT_W, 16, width of the word-count register.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; launches a transfer. Ignored unless in IDLE.
- abort  in  1  level; terminates the transfer at the next cycle.
- base_adr  in  AW  byte address of the first word, sampled on `start`.
- word_count  in  CNT_W  number of DW words to write, sampled on `start`.
- fifo_rdata  in  DW  show-ahead FIFO head word; valid when `fifo_empty`=0.
- fifo_empty  in  1  FIFO empty.
- fifo_level  in  5  words currently in the FIFO, saturating at 16.
- fifo_rd  out  1  pops the FIFO head; combinational, equal to m_wb_ack_i & m_wb_stb_o.
- m_wb_adr_o  out  AW  byte address.
- m_wb_dat_o  out  DW  write data; equal to `fifo_rdata` while `m_wb_stb_o`=1, otherwise 0.
- m_wb_sel_o  out  DW/8  all ones while `m_wb_stb_o`=1, otherwise 0.
- m_wb_we_o, m_wb_cyc_o, m_wb_stb_o  out  1 each  Wishbone control.
- m_wb_cti_o  out  3  cycle type identifier.
- m_wb_bte_o  out  2  burst type extension; constant 2'b00 (linear).
- m_wb_ack_i, m_wb_err_i  in  1 each  slave responses.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse on successful completion.
- error  out  1  sticky; set by `m_wb_err_i`, cleared by the next accepted `start`.

## Operation
Reset values: all outputs 0; state IDLE; internal counters 0.

Registers:
- `adr_r` (AW bits): current byte address.
- `remain` (CNT_W bits): words still to write.
- `beats` (5 bits): beats left in the current burst.

States:
- **IDLE**
  - On `start`: latch `base_adr` into `adr_r` and `word_count` into `remain`; clear `error`.
  - If `word_count`==0, go to DONE; otherwise go to WAIT.
- **WAIT**
  - Let `n` = min(BURST_LEN, `remain`).
  - When `fifo_level` >= `n`: load `beats`=`n`, assert cyc, stb and we, go to BURST.
- **BURST**
  - Each cycle with `m_wb_ack_i`=1:
    - pop the FIFO;
    - `adr_r` += DW/8 (modulo 2^AW);
    - decrement `remain` and `beats`.
  - On the ack with `beats`==1: drop cyc/stb/we in the same clock edge.
    - If `remain` becomes 0, go to DONE; otherwise go to WAIT.
- **DONE**: pulse `done` for one cycle, go to IDLE.

Cycle type (`m_wb_cti_o`):
- 3'b010 on every beat except the last beat of a burst.
- 3'b111 on the last beat.
- 3'b000 when `n`==1 (classic single cycle).

Error handling: `m_wb_err_i` while stb=1 sets `error`, drops cyc/stb immediately, and returns to IDLE without `done`. The FIFO is not popped and `remain` is retained, for debug visibility only.

Abort: `abort`=1 in any non-IDLE state drops cyc/stb on the next edge and returns to IDLE with no `done`. An ack arriving in that same cycle still completes its beat (pop and address increment).

If `m_wb_ack_i` and `m_wb_err_i` are both high, err wins and there is no pop.

Bursts never stall mid-way for FIFO data, because WAIT guarantees `n` words are present before the burst starts.

## Timing
- `start` to first stb, with the FIFO already holding `n` words: 2 cycles (IDLE→WAIT, WAIT→BURST).
- Back-to-back acks give one beat per cycle.
- Between bursts there is 1 cycle in WAIT with cyc=0, which lets the interconnect re-arbitrate.
- `done` is asserted one cycle after the last ack and is high for exactly 1 cycle; `busy` falls with it.
- `start` while busy is ignored.
- Reset mid-burst clears cyc/stb asynchronously.

## Structure
- Shared package `sd_dma_pkg`:
  - CTI constants: CTI_CLASSIC=3'b000, CTI_INCR=3'b010, CTI_EOB=3'b111.
  - State enumeration.
  - Function `min_beats(remain, BURST_LEN)`.
- No sub-module; the existing `sd_rx_fifo` is instantiated by the parent, not inside this block.

## Test plan
- BURST_LEN=4, word_count=8, FIFO preloaded 0x1..0x8, base 0x1000, zero-wait ack → two bursts at 0x1000–0x100C and 0x1010–0x101C; cti 010,010,010,111 per burst; `done` 1 cycle after the 8th ack.
- word_count=6, BURST_LEN=4 → bursts of 4 and 2 beats; second burst cti 010,111; `remain`=0.
- word_count=1 → single beat with cti=000; word_count=0 → `done` 1 cycle after WAIT is skipped, no cyc.
- `m_wb_err_i` on the 3rd beat → cyc drops next edge, `error`=1, no `done`, 2 FIFO pops; the next `start` clears `error`.
- `abort` during WAIT with `fifo_level`=2 < `n` → IDLE next cycle, no bus cycle issued; base 0xFFFF_FFFC with 2 words → addresses 0xFFFF_FFFC then 0x0000_0000.
- Random ack wait states (0–3 cycles) with FIFO refilled at a random rate, 64 words → memory model contents match the FIFO input order exactly.
